mc_control_unit: RTL and testbench

- Parametrised successor to the multicycle control FSM that drives the RV64 multicycle datapath (PC, IR, register bank, A/B, ALU, ALUOut, MDR, write-back mux).
- Adds ready/req handshakes to instruction and data memory, so memories may stall for any number of wait states.
- Adds a wait-state timeout, branch support (BEQ/BNE), LUI, sticky illegal-instruction/timeout trap, and a retired-instruction counter.

---
 rtl/mc_ctrl_pkg.sv | 59 +++++
 rtl/mc_control_unit_wait_timer.sv | 38 +++
 rtl/mc_control_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit.
//   state_t    : controller state encoding (also driven on state_out)
//   ALU_*      : alu_op codes understood by the datapath ALU
//   OP_*, F3_* : instruction decode constants
//   MUX_*      : datapath mux select values
//   CAUSE_*    : trap_cause encodings
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EX_R   = 4'd3,
        ST_EX_I   = 4'd4,
        ST_LUI    = 4'd5,
        ST_WB_ALU = 4'd6,
        ST_ADDR   = 4'd7,
        ST_MEM_RD = 4'd8,
        ST_WB_MEM = 4'd9,
        ST_MEM_WR = 4'd10,
        ST_BR     = 4'd11,
        ST_TRAP   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;
    localparam logic [2:0] ALU_XOR    = 3'b100;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic       MUX_A_PC    = 1'b0;
    localparam logic       MUX_A_REG   = 1'b1;
    localparam logic [1:0] MUX_B_REG   = 2'b00;
    localparam logic [1:0] MUX_B_FOUR  = 2'b01;
    localparam logic [1:0] MUX_B_IMM   = 2'b10;
    localparam logic [1:0] MUX_B_IMM_S = 2'b11;
    localparam logic       PC_SRC_ALU  = 1'b0;
    localparam logic       PC_SRC_OUT  = 1'b1;
    localparam logic       WB_ALUOUT   = 1'b0;
    localparam logic       WB_MDR      = 1'b1;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

endpackage

// File: rtl/mc_control_unit_wait_timer.sv
// Wait-state timer for memory handshakes.
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : controller is in a state waiting on a ready
//   ready      : the ready being waited on
//   expire     : last allowed cycle has passed without ready (TIMEOUT != 0)
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic expire
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Outside a wait state the count is held at zero, so every wait
    // state is entered with a fresh count.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!active || ready)
            wait_cnt_d = '0;
        else if (wait_cnt_q != '1)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt_q <= '0;
        else        wait_cnt_q <= wait_cnt_d;
    end

    // A ready arriving in the final cycle wins over the timeout.
    assign expire = (TIMEOUT != 0) && active && !ready && (wait_cnt_q == LAST);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the RV64 multicycle datapath with ready/req
// memory handshakes, wait-state timeout, BEQ/BNE, LUI, sticky trap and a
// retired-instruction counter.
//   Inputs : clk, rst (async active-low), opcode/funct3/funct7_5 from IR,
//            alu_zero, imem_ready, dmem_ready
//   Outputs: memory requests, datapath load enables and mux selects,
//            alu_op, state_out (debug), trap/trap_cause, retired
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter int EN_BNE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             load_a,
    output logic             load_b,
    output logic             load_alu_out,
    output logic             load_mdr,
    output logic             sel_mux_a,
    output logic [1:0]       sel_mux_b,
    output logic             sel_wb,
    output logic [2:0]       alu_op,
    output logic [3:0]       state_out,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);
    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire, legal, is_beq, is_bne;
    logic             in_wait, wait_ready, expire;

    // Kept outside the FSM block so the timer's expire path has no
    // combinational dependence on the FSM outputs.
    assign in_wait    = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                        (state_q == ST_MEM_WR);
    assign wait_ready = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
    assign is_beq     = (funct3 == F3_BEQ);
    assign is_bne     = (EN_BNE != 0) && (funct3 == F3_BNE);

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst),
        .active (in_wait),
        .ready  (wait_ready),
        .expire (expire)
    );

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        legal        = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_alu_out = 1'b0;
        load_mdr     = 1'b0;
        sel_mux_a    = MUX_A_PC;
        sel_mux_b    = MUX_B_REG;
        sel_wb       = WB_ALUOUT;
        alu_op       = ALU_PASS_B;
        unique case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req  = 1'b1;
                sel_mux_b = MUX_B_FOUR;
                alu_op    = ALU_ADD;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                // Branch target PC + imm<<1 is precomputed into ALUOut.
                load_a       = 1'b1;
                load_b       = 1'b1;
                load_alu_out = 1'b1;
                sel_mux_b    = MUX_B_IMM_S;
                alu_op       = ALU_ADD;
                case (opcode)
                    OP_R:               state_d = ST_EX_R;
                    OP_I:               state_d = ST_EX_I;
                    OP_LOAD, OP_STORE:  state_d = ST_ADDR;
                    OP_BRANCH:          state_d = ST_BR;
                    OP_LUI:             state_d = ST_LUI;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_EX_R, ST_EX_I: begin
                sel_mux_a = MUX_A_REG;
                sel_mux_b = (state_q == ST_EX_I) ? MUX_B_IMM : MUX_B_REG;
                legal     = 1'b1;
                if (funct3 == F3_ADD)
                    alu_op = (state_q == ST_EX_R && funct7_5) ? ALU_SUB : ALU_ADD;
                else if (funct3 == F3_AND)
                    alu_op = ALU_AND;
                else if (funct3 == F3_XOR)
                    alu_op = ALU_XOR;
                else
                    legal = 1'b0;
                // Immediate form has no SUB encoding.
                if (state_q == ST_EX_I && funct3 == F3_ADD && funct7_5)
                    alu_op = ALU_ADD;
                if (legal) begin
                    load_alu_out = 1'b1;
                    state_d      = ST_WB_ALU;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_LUI: begin
                sel_mux_b    = MUX_B_IMM;
                alu_op       = ALU_PASS_B;
                load_alu_out = 1'b1;
                state_d      = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_ADDR: begin
                sel_mux_a    = MUX_A_REG;
                sel_mux_b    = MUX_B_IMM;
                alu_op       = ALU_ADD;
                load_alu_out = 1'b1;
                state_d      = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    load_mdr = 1'b1;
                    state_d  = ST_WB_MEM;
                end else if (expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WB_MEM: begin
                reg_write = 1'b1;
                sel_wb    = WB_MDR;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_MEM_WR: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ready) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_BR: begin
                sel_mux_a = MUX_A_REG;
                sel_mux_b = MUX_B_REG;
                alu_op    = ALU_SUB;
                if (is_beq || is_bne) begin
                    if ((is_beq && alu_zero) || (is_bne && !alu_zero)) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_OUT;
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RST;
        endcase
    end

    assign retired_d = retired_q + CNT_W'(retire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RST;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign state_out  = state_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
    // Hand-written state encodings and control rows.
    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
        S_EX_R = 4'd3, S_EX_I = 4'd4, S_LUI = 4'd5, S_WB_ALU = 4'd6,
        S_ADDR = 4'd7, S_MEM_RD = 4'd8, S_WB_MEM = 4'd9, S_MEM_WR = 4'd10,
        S_BR = 4'd11, S_TRAP = 4'd12;

    // {imem,dmem,we,pcw,pcsrc,irw,regw}_{la,lb,lalu,lmdr}_{ma,mb}_{wb}_{alu}
    localparam logic [17:0] C_NONE    = 18'b0000000_0000_000_0_000;
    localparam logic [17:0] C_FWAIT   = 18'b1000000_0000_001_0_001;
    localparam logic [17:0] C_FRDY    = 18'b1001010_0000_001_0_001;
    localparam logic [17:0] C_DEC     = 18'b0000000_1110_011_0_001;
    localparam logic [17:0] C_EXR_ADD = 18'b0000000_0010_100_0_001;
    localparam logic [17:0] C_EXR_AND = 18'b0000000_0010_100_0_011;
    localparam logic [17:0] C_EXI_XOR = 18'b0000000_0010_110_0_100;
    localparam logic [17:0] C_LUI     = 18'b0000000_0010_010_0_000;
    localparam logic [17:0] C_WBALU   = 18'b0000001_0000_000_0_000;
    localparam logic [17:0] C_ADDR    = 18'b0000000_0010_110_0_001;
    localparam logic [17:0] C_RDW     = 18'b0100000_0000_000_0_000;
    localparam logic [17:0] C_RDR     = 18'b0100000_0001_000_0_000;
    localparam logic [17:0] C_WBMEM   = 18'b0000001_0000_000_1_000;
    localparam logic [17:0] C_WR      = 18'b0110000_0000_000_0_000;
    localparam logic [17:0] C_BR_NT   = 18'b0000000_0000_100_0_010;
    localparam logic [17:0] C_BR_T    = 18'b0001100_0000_100_0_010;

    // {opcode, funct3, funct7_5}
    localparam logic [10:0] I_ADD  = {7'b0110011, 3'b000, 1'b0};
    localparam logic [10:0] I_AND  = {7'b0110011, 3'b111, 1'b0};
    localparam logic [10:0] I_LD   = {7'b0000011, 3'b011, 1'b0};
    localparam logic [10:0] I_SW   = {7'b0100011, 3'b011, 1'b0};
    localparam logic [10:0] I_BEQ  = {7'b1100011, 3'b000, 1'b0};
    localparam logic [10:0] I_BNE  = {7'b1100011, 3'b001, 1'b0};
    localparam logic [10:0] I_LUI  = {7'b0110111, 3'b000, 1'b0};
    localparam logic [10:0] I_XORI = {7'b0010011, 3'b100, 1'b0};
    localparam logic [10:0] I_BAD  = {7'b1111111, 3'b000, 1'b0};

    logic clk = 1'b0, rst = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic funct7_5 = 1'b0, alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, dmem_we, pc_write, pc_src, ir_write, reg_write;
    logic load_a, load_b, load_alu_out, load_mdr, sel_mux_a, sel_wb, trap;
    logic [1:0] sel_mux_b, trap_cause;
    logic [2:0] alu_op, retired;
    logic [3:0] state_out;

    mc_control_unit #(.TIMEOUT(4), .CNT_W(3), .EN_BNE(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_zero(alu_zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .reg_write(reg_write), .load_a(load_a), .load_b(load_b),
        .load_alu_out(load_alu_out), .load_mdr(load_mdr), .sel_mux_a(sel_mux_a),
        .sel_mux_b(sel_mux_b), .sel_wb(sel_wb), .alu_op(alu_op),
        .state_out(state_out), .trap(trap), .trap_cause(trap_cause),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Observed vector: {state, controls, trap, cause, retired}
    logic [27:0] act;
    assign act = {state_out, imem_req, dmem_req, dmem_we, pc_write, pc_src,
                  ir_write, reg_write, load_a, load_b, load_alu_out, load_mdr,
                  sel_mux_a, sel_mux_b, sel_wb, alu_op, trap, trap_cause, retired};

    logic [27:0] exp_q[$];
    string       name_q[$];
    int          checks = 0, errors = 0;
    logic        exp_trap = 1'b0;
    logic [1:0]  exp_cause = 2'b00;
    logic [2:0]  exp_ret = 3'd0;
    event        sample_ev;

    // Monitor: compares on every negedge, or on demand for async checks.
    initial begin
        logic [27:0] e;
        string n;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (state %0d vs %0d)",
                             n, act, e, act[27:24], e[27:24]);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] st, input logic [17:0] c);
        exp_q.push_back({st, c, exp_trap, exp_cause, exp_ret});
        name_q.push_back(nm);
    endtask

    task automatic cyc(input string nm, input logic [10:0] ir, input logic z,
                       input logic ird, input logic drd,
                       input logic [3:0] st, input logic [17:0] c);
        @(posedge clk); #1;
        {opcode, funct3, funct7_5} = ir;
        alu_zero   = z;
        imem_ready = ird;
        dmem_ready = drd;
        push(nm, st, c);
    endtask

    // Reset asserted just after a negedge and checked before the next
    // posedge, so the check sees only the asynchronous path.
    task automatic do_reset(input string nm);
        @(negedge clk); #1;
        rst = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_trap = 1'b0; exp_cause = 2'b00; exp_ret = 3'd0;
        #1;
        push(nm, S_RST, C_NONE);
        ->sample_ev;
        @(negedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        do_reset("reset");
        // ADD, ready at once
        cyc("add_fetch",  I_ADD, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("add_decode", I_ADD, 0, 0, 0, S_DECODE, C_DEC);
        cyc("add_exr",    I_ADD, 0, 0, 0, S_EX_R,   C_EXR_ADD);
        cyc("add_wb",     I_ADD, 0, 0, 0, S_WB_ALU, C_WBALU);
        exp_ret++;
        // LD with three wait states
        cyc("ld_fetch",   I_LD, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("ld_decode",  I_LD, 0, 0, 0, S_DECODE, C_DEC);
        cyc("ld_addr",    I_LD, 0, 0, 0, S_ADDR,   C_ADDR);
        for (int i = 0; i < 3; i++)
            cyc("ld_rd_wait", I_LD, 0, 0, 0, S_MEM_RD, C_RDW);
        cyc("ld_rd_rdy",  I_LD, 0, 0, 1, S_MEM_RD, C_RDR);
        cyc("ld_wb",      I_LD, 0, 0, 0, S_WB_MEM, C_WBMEM);
        exp_ret++;
        // SW with fetch and write wait states
        cyc("sw_fwait",   I_SW, 0, 0, 0, S_FETCH,  C_FWAIT);
        cyc("sw_fwait",   I_SW, 0, 0, 0, S_FETCH,  C_FWAIT);
        cyc("sw_fetch",   I_SW, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("sw_decode",  I_SW, 0, 0, 0, S_DECODE, C_DEC);
        cyc("sw_addr",    I_SW, 0, 0, 0, S_ADDR,   C_ADDR);
        cyc("sw_wr_wait", I_SW, 0, 0, 0, S_MEM_WR, C_WR);
        cyc("sw_wr_rdy",  I_SW, 0, 0, 1, S_MEM_WR, C_WR);
        exp_ret++;
        // BEQ taken
        cyc("beq_fetch",  I_BEQ, 1, 1, 0, S_FETCH,  C_FRDY);
        cyc("beq_decode", I_BEQ, 1, 0, 0, S_DECODE, C_DEC);
        cyc("beq_taken",  I_BEQ, 1, 0, 0, S_BR,     C_BR_T);
        exp_ret++;
        // BNE not taken
        cyc("bne_fetch",  I_BNE, 1, 1, 0, S_FETCH,  C_FRDY);
        cyc("bne_decode", I_BNE, 1, 0, 0, S_DECODE, C_DEC);
        cyc("bne_ntaken", I_BNE, 1, 0, 0, S_BR,     C_BR_NT);
        exp_ret++;
        // LUI
        cyc("lui_fetch",  I_LUI, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("lui_decode", I_LUI, 0, 0, 0, S_DECODE, C_DEC);
        cyc("lui_ex",     I_LUI, 0, 0, 0, S_LUI,    C_LUI);
        cyc("lui_wb",     I_LUI, 0, 0, 0, S_WB_ALU, C_WBALU);
        exp_ret++;
        // XORI
        cyc("xori_fetch", I_XORI, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("xori_decode",I_XORI, 0, 0, 0, S_DECODE, C_DEC);
        cyc("xori_ex",    I_XORI, 0, 0, 0, S_EX_I,   C_EXI_XOR);
        cyc("xori_wb",    I_XORI, 0, 0, 0, S_WB_ALU, C_WBALU);
        exp_ret++;
        // AND: eighth retirement wraps the 3-bit counter to 0
        cyc("and_fetch",  I_AND, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("and_decode", I_AND, 0, 0, 0, S_DECODE, C_DEC);
        cyc("and_ex",     I_AND, 0, 0, 0, S_EX_R,   C_EXR_AND);
        cyc("and_wb",     I_AND, 0, 0, 0, S_WB_ALU, C_WBALU);
        exp_ret++;
        // Ready in the 4th fetch cycle beats the timeout; then illegal opcode
        for (int i = 0; i < 3; i++)
            cyc("late_fwait", I_BAD, 0, 0, 0, S_FETCH, C_FWAIT);
        cyc("late_frdy",  I_BAD, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("bad_decode", I_BAD, 0, 0, 0, S_DECODE, C_DEC);
        exp_trap = 1'b1; exp_cause = 2'b10;
        for (int i = 0; i < 10; i++)
            cyc("illegal_trap", I_BAD, 0, 1, 1, S_TRAP, C_NONE);
        // Fetch timeout
        do_reset("reset_from_trap");
        for (int i = 0; i < 4; i++)
            cyc("to_fwait", I_ADD, 0, 0, 0, S_FETCH, C_FWAIT);
        exp_trap = 1'b1; exp_cause = 2'b01;
        cyc("timeout_trap", I_ADD, 0, 1, 0, S_TRAP, C_NONE);
        cyc("timeout_trap", I_ADD, 0, 1, 0, S_TRAP, C_NONE);
        // Reset in the middle of a store
        do_reset("reset_from_timeout");
        cyc("sw2_fetch",  I_SW, 0, 1, 0, S_FETCH,  C_FRDY);
        cyc("sw2_decode", I_SW, 0, 0, 0, S_DECODE, C_DEC);
        cyc("sw2_addr",   I_SW, 0, 0, 0, S_ADDR,   C_ADDR);
        cyc("sw2_wr",     I_SW, 0, 0, 0, S_MEM_WR, C_WR);
        do_reset("reset_mid_write");
        cyc("post_rst_fetch", I_SW, 0, 0, 1, S_FETCH, C_FWAIT);
        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
